vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning VRAM address width (2048 bytes).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning CPU write-buffer entries (power of two, 2..16).
REQ-003 SHALL have parameter STARVE_LIM, default 15, meaning the number of consecutive denied drain cycles before the drain overrides VGA.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_wr_req in 1, cpu_wr_addr in ADDR_W, cpu_wr_data in 8: a one-cycle CPU write pulse.
REQ-007 SHALL have port cpu_wr_full  output  1  high while the write buffer holds FIFO_DEPTH entries (combinational from count).
REQ-008 SHALL have ports vga_rd_req in 1, vga_rd_addr in ADDR_W, vga_rd_grant out 1 (combinational), vga_rd_data out 8, vga_rd_valid out 1.
REQ-009 SHALL have ports ram_addr out ADDR_W, ram_wdata out 8, ram_we out 1 (all combinational from the grant), and ram_rdata in 8 (synchronous RAM, valid one cycle after the address).
REQ-010 SHALL have ports wr_overflow out 1 (sticky) and busy out 1 (buffer non-empty).

Function
REQ-011 SHALL issue at most one RAM operation per cycle; ram_we SHALL be 0 in every cycle without a drain grant.
REQ-012 SHALL use the priority VGA read > CPU read (macro) > buffer drain, except as REQ-015 states.
REQ-013 SHALL push on cpu_wr_req when count<FIFO_DEPTH; a push while full SHALL be dropped and set wr_overflow, even if a pop occurs in the same cycle.
REQ-014 SHALL handle a drain grant as follows: pop the head, drive ram_addr/ram_wdata from the head with ram_we=1, and write entries in push order.
REQ-015 SHALL keep a starve counter: increment when the buffer is non-empty and the drain is not granted, clear on a drain grant or when the buffer is empty; at STARVE_LIM the drain SHALL win over VGA for exactly one cycle, with vga_rd_grant=0.
REQ-016 SHALL make vga_rd_grant=vga_rd_req AND NOT starve override; the VGA requester holds its request until granted.
REQ-017 SHALL handle a granted VGA read in cycle N as follows: ram_addr=vga_rd_addr in cycle N, ram_rdata captured at the N+1 edge, vga_rd_data/vga_rd_valid visible in cycle N+2, and valid is a one-cycle pulse.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop when not full.
REQ-019 SHALL wrap read and write pointers modulo FIFO_DEPTH, with no gap or duplicate at wrap.
REQ-020 SHALL keep vga_rd_data holding its last value when vga_rd_valid=0.

Reset
REQ-021 SHALL, while reset_n=0 (asynchronous), clear pointers, count, starve counter, wr_overflow, vga_rd_valid, vga_rd_data=8'h00 (and cpu_rd_valid and cpu_rd_data under the macro).
REQ-022 SHALL discard buffered writes and in-flight reads on a reset mid-operation; ram_we SHALL be 0 during reset.
REQ-023 SHALL allow the first grant in the first cycle after reset_n rises.

Configuration
REQ-024 SHALL use macro VRAM_CPU_READ_EN to add ports cpu_rd_req in 1, cpu_rd_addr in ADDR_W, cpu_rd_grant out 1, cpu_rd_data out 8, cpu_rd_valid out 1.
REQ-025 SHALL, with VRAM_CPU_READ_EN, grant a CPU read only when the buffer is empty and there is no VGA grant, using the same N+2 latency as REQ-017; the buffer-empty condition prevents read-after-write hazards.
REQ-026 SHALL, without VRAM_CPU_READ_EN, omit these ports and the logic, and the priority reduces to VGA > drain.

Verification
REQ-027 SHALL cover reset: write 3 entries, assert reset_n=0 mid-drain -> busy=0, ram_we=0, wr_overflow=0 immediately, and no further writes occur.
REQ-028 SHALL cover ordering: push (0x010,0x41),(0x011,0x42),(0x7FF,0x43) with VGA idle -> three ram_we cycles in order, busy falls after the third.
REQ-029 SHALL cover overflow: 5 pushes back-to-back while VGA is held -> cpu_wr_full after the 4th, 5th dropped, wr_overflow=1, 4 writes later.
REQ-030 SHALL cover starvation: buffer non-empty, vga_rd_req held high -> after 15 denied cycles one drain cycle with vga_rd_grant=0, then VGA resumes.
REQ-031 SHALL cover VGA read: RAM preloaded 0x5A at 0x123, vga_rd_req granted in cycle N -> vga_rd_data=0x5A, vga_rd_valid=1 in N+2 only.
REQ-032 SHALL cover the macro: with VRAM_CPU_READ_EN, cpu_rd_req to 0x020 while a write to 0x020 is pending -> read waits for drain and returns the new data.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter. It serves VGA reads, drains a CPU
// write buffer, and optionally serves CPU reads (macro VRAM_CPU_READ_EN).
// Priority: VGA read > CPU read > buffer drain. A starve counter lets the
// drain take one cycle ahead of VGA after STARVE_LIM consecutive denials.
//
// Handshakes: a request is a level that the requester holds until the
// combinational grant is seen high in the same cycle. The operation takes
// place in the grant cycle N. Read data comes back with a one-cycle *_valid
// pulse in cycle N+2, and *_data keeps its value between pulses.
// CPU writes are fire-and-forget pulses, accepted whenever cpu_wr_full is low.
module vram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_data,
  output logic              cpu_wr_full,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic              vga_rd_grant,
  output logic [7:0]        vga_rd_data,
  output logic              vga_rd_valid,
`ifdef VRAM_CPU_READ_EN
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_grant,
  output logic [7:0]        cpu_rd_data,
  output logic              cpu_rd_valid,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              wr_overflow,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

  // Write buffer entries hold {addr, data}
  logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             overflow_q, overflow_d;
  logic             vga_pend_q, vga_pend_d, vga_valid_q, vga_valid_d;
  logic [7:0]       vga_data_q, vga_data_d;
`ifdef VRAM_CPU_READ_EN
  logic             cpu_pend_q, cpu_pend_d, cpu_valid_q, cpu_valid_d;
  logic [7:0]       cpu_data_q, cpu_data_d;
`endif

  logic nonempty, full, starve_ovr, vga_grant, drain_grant, cpu_grant, push;
  logic [ENT_W-1:0] head;

  // Arbitration: VGA first unless the drain has starved, then CPU read, then drain
  always_comb begin
    nonempty    = (count_q != '0);
    full        = (count_q == DEPTH_C);
    starve_ovr  = nonempty && (starve_q >= STV_MAX);
    vga_grant   = vga_rd_req && !starve_ovr;
`ifdef VRAM_CPU_READ_EN
    // Reads wait for an empty buffer so they never overtake a pending write
    cpu_grant   = cpu_rd_req && !nonempty && !vga_grant;
`else
    cpu_grant   = 1'b0;
`endif
    drain_grant = nonempty && (starve_ovr || !vga_rd_req);
    push        = cpu_wr_req && !full;
    head        = fifo_q[rd_ptr_q];
  end

  // Next state for write buffer, starve counter and read return pipes
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {cpu_wr_addr, cpu_wr_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (drain_grant) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !drain_grant) begin
      count_d = count_q + 1'b1;
    end else if (!push && drain_grant) begin
      count_d = count_q - 1'b1;
    end
    // A write arriving while full is lost even if a pop frees a slot this cycle
    overflow_d  = overflow_q | (cpu_wr_req & full);
    starve_d    = (!nonempty || drain_grant) ? '0 : starve_q + 1'b1;
    vga_pend_d  = vga_grant;
    vga_valid_d = vga_pend_q;
    vga_data_d  = vga_pend_q ? ram_rdata : vga_data_q;
`ifdef VRAM_CPU_READ_EN
    cpu_pend_d  = cpu_grant;
    cpu_valid_d = cpu_pend_q;
    cpu_data_d  = cpu_pend_q ? ram_rdata : cpu_data_q;
`endif
  end

  // RAM port follows whichever requester holds the grant this cycle
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (vga_grant) begin
      ram_addr = vga_rd_addr;
`ifdef VRAM_CPU_READ_EN
    end else if (cpu_grant) begin
      ram_addr = cpu_rd_addr;
`endif
    end else if (drain_grant) begin
      ram_addr  = head[ENT_W-1:8];
      ram_wdata = head[7:0];
      ram_we    = 1'b1;
    end
  end

  // State registers, cleared asynchronously so buffered work is discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      overflow_q  <= 1'b0;
      vga_pend_q  <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= 8'h00;
`ifdef VRAM_CPU_READ_EN
      cpu_pend_q  <= 1'b0;
      cpu_valid_q <= 1'b0;
      cpu_data_q  <= 8'h00;
`endif
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      overflow_q  <= overflow_d;
      vga_pend_q  <= vga_pend_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
`ifdef VRAM_CPU_READ_EN
      cpu_pend_q  <= cpu_pend_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_data_q  <= cpu_data_d;
`endif
    end
  end

  assign cpu_wr_full  = full;
  assign busy         = nonempty;
  assign wr_overflow  = overflow_q;
  assign vga_rd_grant = vga_grant;
  assign vga_rd_valid = vga_valid_q;
  assign vga_rd_data  = vga_data_q;
`ifdef VRAM_CPU_READ_EN
  assign cpu_rd_grant = cpu_grant;
  assign cpu_rd_valid = cpu_valid_q;
  assign cpu_rd_data  = cpu_data_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter (default parameters).
// A synchronous RAM lives in the bench. A queue-based reference model predicts
// every output in every cycle. Hand-written sequences cover ordering,
// overflow, starvation, reset, read latency and (with VRAM_CPU_READ_EN)
// CPU read-after-write.
module tb_vram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int LIM    = 15;

  logic              clk, reset_n;
  logic              cpu_wr_req, cpu_wr_full;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [7:0]        cpu_wr_data;
  logic              vga_rd_req, vga_rd_grant, vga_rd_valid;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [7:0]        vga_rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic              ram_we, wr_overflow, busy;
`ifdef VRAM_CPU_READ_EN
  logic              cpu_rd_req, cpu_rd_grant, cpu_rd_valid;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic [7:0]        cpu_rd_data;
`endif

  vram_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_full(cpu_wr_full),
    .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr), .vga_rd_grant(vga_rd_grant),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
`ifdef VRAM_CPU_READ_EN
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_grant(cpu_rd_grant),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
`endif
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .wr_overflow(wr_overflow), .busy(busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- synchronous RAM (with preload port) ----------------
  logic [7:0]        ram_mem [2048];
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;
  always @(posedge clk) begin
    if (pre_en) ram_mem[pre_addr] <= pre_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { int due; logic [7:0] data; } rd_t;
  wr_t        wq[$];
  rd_t        vq[$];
  rd_t        cq[$];
  logic [7:0] m_mem [2048];
  int         m_starve, cyc;
  logic       m_ovf;
  logic [7:0] m_vdata, m_cdata;
  logic       last_e_vg, last_e_cg;
  logic       obs_we, obs_vg, obs_cg;
  logic [ADDR_W-1:0] obs_addr;
  logic [7:0] obs_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete(); vq.delete(); cq.delete();
    m_starve = 0; m_ovf = 1'b0; m_vdata = 8'h00; m_cdata = 8'h00; cyc = 0;
  endtask

  // Drive one cycle's inputs, check all outputs against the model, advance model.
  task automatic apply(input logic wr, input logic [ADDR_W-1:0] wa, input logic [7:0] wd,
                       input logic vr, input logic [ADDR_W-1:0] va,
                       input logic cr, input logic [ADDR_W-1:0] ca);
    logic empty, ovr, e_vg, e_dr, e_cg, e_vv, e_cv, full_before;
    cpu_wr_req = wr; cpu_wr_addr = wa; cpu_wr_data = wd;
    vga_rd_req = vr; vga_rd_addr = va;
`ifdef VRAM_CPU_READ_EN
    cpu_rd_req = cr; cpu_rd_addr = ca;
`endif
    #1;
    empty = (wq.size() == 0);
    ovr   = !empty && (m_starve >= LIM);
    e_vg  = vr && !ovr;
    e_dr  = !empty && (ovr || !vr);
    e_cg  = cr && empty && !e_vg;
    e_vv  = 1'b0;
    e_cv  = 1'b0;
    if (vq.size() > 0 && vq[0].due == cyc) begin
      e_vv = 1'b1; m_vdata = vq[0].data; void'(vq.pop_front());
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      e_cv = 1'b1; m_cdata = cq[0].data; void'(cq.pop_front());
    end
    check("vga_rd_grant", vga_rd_grant, e_vg);
    check("ram_we", ram_we, e_dr);
    check("busy", busy, !empty);
    check("cpu_wr_full", cpu_wr_full, wq.size() == DEPTH);
    check("wr_overflow", wr_overflow, m_ovf);
    check("vga_rd_valid", vga_rd_valid, e_vv);
    check("vga_rd_data", vga_rd_data, m_vdata);
`ifdef VRAM_CPU_READ_EN
    check("cpu_rd_grant", cpu_rd_grant, e_cg);
    check("cpu_rd_valid", cpu_rd_valid, e_cv);
    check("cpu_rd_data", cpu_rd_data, m_cdata);
`endif
    if (e_dr) begin
      check("drain_addr", ram_addr, wq[0].addr);
      check("drain_wdata", ram_wdata, wq[0].data);
    end else if (e_vg) begin
      check("vga_ram_addr", ram_addr, va);
    end else if (e_cg) begin
      check("cpu_ram_addr", ram_addr, ca);
    end
    obs_we = ram_we; obs_vg = vga_rd_grant; obs_addr = ram_addr; obs_wdata = ram_wdata;
`ifdef VRAM_CPU_READ_EN
    obs_cg = cpu_rd_grant;
`else
    obs_cg = 1'b0;
`endif
    last_e_vg = e_vg; last_e_cg = e_cg;
    // advance the model to the next cycle
    if (e_vg) vq.push_back('{due: cyc + 2, data: m_mem[va]});
    if (e_cg) cq.push_back('{due: cyc + 2, data: m_mem[ca]});
    full_before = (wq.size() == DEPTH);
    if (e_dr) begin
      m_mem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
    end
    if (wr) begin
      if (full_before) m_ovf = 1'b1;
      else wq.push_back('{addr: wa, data: wd});
    end
    m_starve = (empty || e_dr) ? 0 : m_starve + 1;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      tick();
    end
  endtask

  // ordering vectors: inputs plus expected RAM port and busy
  typedef struct packed {
    logic wr; logic [ADDR_W-1:0] wa; logic [7:0] wd;
    logic e_we; logic [ADDR_W-1:0] e_addr; logic [7:0] e_wdata; logic e_busy;
  } vec_t;
  vec_t vecs[5];

  int n_wr, denied, found;
  logic [ADDR_W-1:0] wr_log[$];
  logic [ADDR_W-1:0] exp_q[$];
  logic r_vr, r_cr;
  logic [ADDR_W-1:0] r_va, r_ca;
  logic [7:0] pv;

  // ---------------- main test ----------------
  initial begin
    reset_n = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_wr_req = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    vga_rd_req = 1'b0; vga_rd_addr = '0;
`ifdef VRAM_CPU_READ_EN
    cpu_rd_req = 1'b0; cpu_rd_addr = '0;
`endif
    model_reset();
    last_e_vg = 1'b0; last_e_cg = 1'b0;

    // preload RAM while in reset
    for (int a = 0; a < 2048; a++) begin
      pv = 8'($urandom_range(0, 255));
      if (a == 'h123) pv = 8'h5A;
      m_mem[a] = pv;
      pre_en = 1'b1; pre_addr = ADDR_W'(a); pre_data = pv;
      @(negedge clk);
    end
    pre_en = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_ram_we", ram_we, 0);
    check("reset_vga_valid", vga_rd_valid, 0);
    check("reset_vga_data", vga_rd_data, 8'h00);
    check("reset_overflow", wr_overflow, 0);
    check("reset_full", cpu_wr_full, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // VGA read granted in the very first cycle after reset, data in N+2 only
    apply(1'b0, '0, '0, 1'b1, 11'h123, 1'b0, '0);
    check("first_cycle_vga_grant", obs_vg, 1);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("vga_n1_valid", vga_rd_valid, 0);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("vga_n2_valid", vga_rd_valid, 1);
    check("vga_n2_data", vga_rd_data, 8'h5A);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("vga_n3_valid", vga_rd_valid, 0);
    check("vga_n3_hold", vga_rd_data, 8'h5A);
    tick();

    // ordering table
    vecs[0] = {1'b1, 11'h010, 8'h41, 1'b0, 11'h000, 8'h00, 1'b0};
    vecs[1] = {1'b1, 11'h011, 8'h42, 1'b1, 11'h010, 8'h41, 1'b1};
    vecs[2] = {1'b1, 11'h7FF, 8'h43, 1'b1, 11'h011, 8'h42, 1'b1};
    vecs[3] = {1'b0, 11'h000, 8'h00, 1'b1, 11'h7FF, 8'h43, 1'b1};
    vecs[4] = {1'b0, 11'h000, 8'h00, 1'b0, 11'h000, 8'h00, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i].wr, vecs[i].wa, vecs[i].wd, 1'b0, '0, 1'b0, '0);
      check($sformatf("ord%0d_we", i), obs_we, vecs[i].e_we);
      check($sformatf("ord%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_we) begin
        check($sformatf("ord%0d_addr", i), obs_addr, vecs[i].e_addr);
        check($sformatf("ord%0d_wdata", i), obs_wdata, vecs[i].e_wdata);
      end
      tick();
    end

    // overflow: 5 pushes while VGA holds the port, 5th dropped
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, ADDR_W'(11'h100 + i), 8'(8'hA0 + i), 1'b1, 11'h200, 1'b0, '0);
      if (i == 4) begin
        check("ovf_full_at_5th", cpu_wr_full, 1);
        check("ovf_flag_before_5th", wr_overflow, 0);
      end
      tick();
    end
    n_wr = 0; wr_log.delete();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      if (i == 0) check("ovf_flag_set", wr_overflow, 1);
      if (obs_we) begin n_wr++; wr_log.push_back(obs_addr); end
      tick();
    end
    check("ovf_write_count", n_wr, 4);
    exp_q = '{11'h100, 11'h101, 11'h102, 11'h103};
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("ovf_write_order", wr_log[i], exp_q[i]);

    // starvation: one entry buffered, VGA held high throughout
    apply(1'b1, 11'h300, 8'h77, 1'b1, 11'h010, 1'b0, '0);
    tick();
    denied = 0; found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      apply(1'b0, '0, '0, 1'b1, 11'h010, 1'b0, '0);
      if (obs_we) begin
        found = 1;
        check("starve_drain_vga_grant", obs_vg, 0);
        check("starve_drain_addr", obs_addr, 11'h300);
      end else if (busy && obs_vg) begin
        denied++;
      end
      tick();
    end
    check("starve_drain_seen", found, 1);
    check("starve_denied_cycles", denied, LIM);
    apply(1'b0, '0, '0, 1'b1, 11'h010, 1'b0, '0);
    check("starve_vga_resumes", obs_vg, 1);
    check("starve_busy_after", busy, 0);
    tick();
    idle(3);

    // reset mid-drain: 3 entries queued behind VGA, reset while draining the second
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, ADDR_W'(11'h050 + i), 8'(8'h11 + i), 1'b1, 11'h400, 1'b0, '0);
      tick();
    end
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("rst_first_drain_addr", obs_addr, 11'h050);
    tick();
    cpu_wr_req = 1'b0; vga_rd_req = 1'b0;
    #1;
    check("rst_pre_we", ram_we, 1);
    check("rst_pre_overflow", wr_overflow, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_overflow", wr_overflow, 0);
    check("rst_full", cpu_wr_full, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      if (obs_we) n_wr++;
      tick();
    end
    check("rst_no_writes_after", n_wr, 0);
    check("rst_entry2_not_written", ram_mem[11'h051], m_mem[11'h051]);
    check("rst_entry3_not_written", ram_mem[11'h052], m_mem[11'h052]);

`ifdef VRAM_CPU_READ_EN
    // CPU read of an address with a pending write waits for the drain
    apply(1'b1, 11'h020, 8'h99, 1'b0, '0, 1'b0, '0);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b1, 11'h020);
    check("raw_read_blocked", obs_cg, 0);
    check("raw_drain_first", obs_we, 1);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b1, 11'h020);
    check("raw_read_granted", obs_cg, 1);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("raw_n1_valid", cpu_rd_valid, 0);
    tick();
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    check("raw_n2_valid", cpu_rd_valid, 1);
    check("raw_n2_data", cpu_rd_data, 8'h99);
    tick();
`endif

    // randomized traffic against the model; requesters hold until granted
    r_vr = 1'b0; r_va = '0; r_cr = 1'b0; r_ca = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(r_vr && !last_e_vg)) begin
        r_vr = ($urandom_range(0, 99) < 60);
        r_va = ADDR_W'($urandom_range(0, 2047));
      end
`ifdef VRAM_CPU_READ_EN
      if (!(r_cr && !last_e_cg)) begin
        r_cr = ($urandom_range(0, 99) < 25);
        r_ca = ADDR_W'($urandom_range(0, 63));
      end
`endif
      apply(($urandom_range(0, 99) < 40), ADDR_W'($urandom_range(0, 63)),
            8'($urandom_range(0, 255)), r_vr, r_va, r_cr, r_ca);
      tick();
    end
    idle(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
